bus_bridge_m_frame_ctrl: RTL and testbench
==========================================

Name: bus_bridge_m_frame_ctrl

Overview:
Bus-B-side initiator of the dual-bus UART bridge, and the far end of the Bus-A bridge slave wrapper. It assembles request frames from a byte-level UART receiver and issues one read or write on Bus B through a standard master port. It then returns a 2-byte response frame through a byte-level UART transmitter. It sits in the Bus-B top in place of a regular master; the UART rx/tx byte engines are existing blocks instantiated alongside it.

Parameters:
BYTE_TIMEOUT_CYCLES, 50000, max idle cycles between request bytes before a partial frame is discarded
BUS_TIMEOUT_CYCLES, 4096, max cycles waiting for grant or completion before an error response
STATUS_OK, 8'h00, status byte for a successful transaction
STATUS_TIMEOUT, 8'hEE, status byte for a bus timeout

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
rx_data  in  8  received UART byte
rx_valid  in  1  one-cycle strobe, rx_data valid
tx_data  out  8  byte to transmit
tx_valid  out  1  tx_data valid; held until tx_ready
tx_ready  in  1  transmitter accepts byte when tx_valid&tx_ready
m_req  out  1  bus request
m_grant  in  1  bus grant
m_address_out  out  16  Bus-B address
m_address_out_valid  out  1  address strobe
m_data_out  out  8  write data
m_data_out_valid  out  1  write data strobe
m_rw  out  1  1=write, 0=read
m_ready  out  1  ready to accept read data
m_data_in  in  8  read data
m_data_in_valid  in  1  read data strobe
m_ack  in  1  transaction acknowledge
m_split_ack  in  1  target has split the transaction
busy  out  1  high in any state except IDLE

Behaviour:
- Clock/reset: one clock; reset is asynchronous and active-low (clk, rst_n).
- Reset: state IDLE. All outputs 0: tx_valid, m_req, m_address_out, m_address_out_valid, m_data_out, m_data_out_valid, m_rw, m_ready, busy. Byte counter and timers 0.
- Request frame, 4 bytes in order: CMD (bit0 = rw, bits[7:1] ignored), ADDR_HI, ADDR_LO, WDATA. WDATA is always sent and ignored for reads.
- States: IDLE -> RX_FRAME -> REQ -> ADDR -> WAIT -> RESP0 -> RESP1 -> IDLE.
- IDLE: first rx_valid stores CMD, moves to RX_FRAME.
- RX_FRAME: each rx_valid stores the next byte and clears the inter-byte timer.
  - If the timer reaches BYTE_TIMEOUT_CYCLES, discard the frame and return to IDLE with no response.
  - After byte 4 is stored, go to REQ the next cycle.
- REQ: m_req=1 and held until WAIT completes. On m_grant go to ADDR.
- ADDR: exactly one cycle.
  - m_address_out_valid=1, m_address_out={ADDR_HI,ADDR_LO}, m_rw=CMD[0].
  - For a write, m_data_out=WDATA and m_data_out_valid=1 in the same cycle.
- WAIT, read: m_ready=1; the first m_data_in_valid captures m_data_in and completes the transaction.
- WAIT, write: m_ack completes the transaction.
- Split: m_split_ack freezes the bus timer; it resumes when m_split_ack deasserts. m_req stays high throughout.
- Bus timeout: the bus timer runs in REQ and WAIT and is cleared on entering REQ. Reaching BUS_TIMEOUT_CYCLES drops m_req and goes to RESP0 with status STATUS_TIMEOUT and data 8'h00.
- On completion: m_req and m_ready drop in the cycle after completion.
- Response frame:
  - RESP0 sends the status byte.
  - RESP1 sends the data byte: read data for a read, echoed WDATA for a write.
  - tx_valid stays high with stable tx_data until tx_ready; advance on the handshake.
- rx_valid outside IDLE/RX_FRAME is dropped (no queueing). The sender must wait for the response before sending the next frame.
- Address drives are registered. m_address_out and m_data_out hold their last value after use; only the valid strobes return to 0.
- Latency, grant available immediately: the last request byte is followed by m_req 1 cycle later and m_address_out_valid 1 cycle after grant.

Optional Feature:
BRIDGE_M_CHECKSUM_EN
- Defined: the request frame has a 5th byte equal to XOR of the first 4 bytes.
  - On mismatch, skip REQ/ADDR/WAIT and go directly to RESP0 with status 8'hCE and data 8'h00.
  - The byte counter ends at 5.
- Undefined: 4-byte frames, no check.

Decomposition:
- Package bus_bridge_pkg:
  - frame byte-count constants (REQ_LEN, RESP_LEN)
  - status codes (STATUS_OK, STATUS_TIMEOUT, STATUS_BADSUM)
  - CMD bit index
  - state enum typedef
- Shared with the Bus-A slave wrapper so both ends agree.
- One natural sub-module: bus_bridge_frame_rx. It handles byte assembly, the inter-byte timeout and the optional checksum, and outputs a frame_valid pulse with rw/addr/wdata. The bus FSM and response TX stay in the top.

Test Plan:
- Write, immediate grant and ack. Bytes 01,40,12,A7 -> one m_address_out_valid with 16'h4012, m_rw=1, m_data_out=A7. Response 00,A7.
- Read. Bytes 00,00,34,xx; target returns 3C on m_data_in_valid after 5 cycles -> m_ready high during WAIT. Response 00,3C.
- Split read. m_split_ack held 6000 cycles, then data 5E -> no timeout, m_req high throughout. Response 00,5E.
- No ack within 4096 cycles -> m_req drops. Response EE,00.
- Partial frame of 2 bytes, then idle 50000 cycles; then a full valid frame -> the first is discarded, only the second executes.
- rst_n asserted in WAIT, with CHECKSUM_EN defined -> all outputs 0 immediately. After release, frame 01,80,04,05,80 gives response 00,05; a bad checksum gives CE,00 with no m_req.

Source files
------------

// File: rtl/bus_bridge_pkg.sv
// Shared constants and FSM state type for both ends of the dual-bus UART bridge.
// BRIDGE_M_CHECKSUM_EN appends an XOR checksum byte to every request frame.
package bus_bridge_pkg;

`ifdef BRIDGE_M_CHECKSUM_EN
  localparam int REQ_LEN = 5;
`else
  localparam int REQ_LEN = 4;
`endif
  localparam int RESP_LEN = 2;

  localparam logic [7:0] STATUS_OK      = 8'h00;
  localparam logic [7:0] STATUS_TIMEOUT = 8'hEE;
  localparam logic [7:0] STATUS_BADSUM  = 8'hCE;

  localparam int CMD_RW_BIT = 0;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RX_FRAME,
    ST_REQ,
    ST_ADDR,
    ST_WAIT,
    ST_RESP0,
    ST_RESP1
  } bridge_state_e;

endpackage

// File: rtl/bus_bridge_frame_rx.sv
// Request-frame assembler: collects CMD/ADDR_HI/ADDR_LO/WDATA (plus checksum when
// BRIDGE_M_CHECKSUM_EN is defined) and discards partial frames after an idle gap.
module bus_bridge_frame_rx
  import bus_bridge_pkg::*;
#(
  parameter int BYTE_TIMEOUT_CYCLES = 50000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  input  logic        rx_en,
  input  logic        rx_first,
  output logic        frame_done,
  output logic        frame_bad,
  output logic        frame_drop,
  output logic        rw,
  output logic [15:0] addr,
  output logic [7:0]  wdata
);

  localparam int TW = $clog2(BYTE_TIMEOUT_CYCLES + 1);
  localparam int CW = $clog2(REQ_LEN + 1);

  logic [CW-1:0] byte_cnt;
  logic [TW-1:0] byte_timer;
  logic [7:0]    addr_hi;
  logic [7:0]    addr_lo;
  logic          take;

  assign take       = rx_en && rx_valid;
  assign frame_done = take && !rx_first && (byte_cnt == CW'(REQ_LEN - 1));
  assign frame_drop = rx_en && !rx_first && !rx_valid &&
                      (byte_timer == TW'(BYTE_TIMEOUT_CYCLES - 1));
  assign addr       = {addr_hi, addr_lo};

`ifdef BRIDGE_M_CHECKSUM_EN
  logic [7:0] csum;

  // The last byte is compared live against the XOR of the four already stored.
  assign frame_bad = frame_done && (rx_data != csum);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      csum <= '0;
    end else if (take) begin
      csum <= rx_first ? rx_data : (csum ^ rx_data);
    end
  end
`else
  assign frame_bad = 1'b0;
`endif

  // NOTE: sequential state uses <= so every flop samples pre-edge values,
  // independent of the order the statements are written in.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the frame byte registers are a handful of flops, not a RAM, so they
      // take the reset like everything else and the bus drives start at 0.
      byte_cnt   <= '0;
      byte_timer <= '0;
      rw         <= 1'b0;
      addr_hi    <= '0;
      addr_lo    <= '0;
      wdata      <= '0;
    end else if (take) begin
      byte_timer <= '0;
      if (rx_first) begin
        byte_cnt <= CW'(1);
        rw       <= rx_data[CMD_RW_BIT];
      end else begin
        byte_cnt <= byte_cnt + CW'(1);
        case (byte_cnt)
          CW'(1):  addr_hi <= rx_data;
          CW'(2):  addr_lo <= rx_data;
          CW'(3):  wdata   <= rx_data;
          default: ;
        endcase
      end
    end else if (frame_drop) begin
      byte_cnt   <= '0;
      byte_timer <= '0;
    end else if (rx_en && !rx_first) begin
      byte_timer <= byte_timer + TW'(1);
    end else begin
      byte_timer <= '0;
    end
  end

endmodule

// File: rtl/bus_bridge_m_frame_ctrl.sv
// Bus-B initiator of the UART bridge: turns a request frame into one bus read/write
// and answers with a status/data frame. BRIDGE_M_CHECKSUM_EN enables the checksum byte.
module bus_bridge_m_frame_ctrl #(
  parameter int         BYTE_TIMEOUT_CYCLES = 50000,
  parameter int         BUS_TIMEOUT_CYCLES  = 4096,
  parameter logic [7:0] STATUS_OK           = 8'h00,
  parameter logic [7:0] STATUS_TIMEOUT      = 8'hEE
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        m_req,
  input  logic        m_grant,
  output logic [15:0] m_address_out,
  output logic        m_address_out_valid,
  output logic [7:0]  m_data_out,
  output logic        m_data_out_valid,
  output logic        m_rw,
  output logic        m_ready,
  input  logic [7:0]  m_data_in,
  input  logic        m_data_in_valid,
  input  logic        m_ack,
  input  logic        m_split_ack,
  output logic        busy
);

  import bus_bridge_pkg::*;

  localparam int BTW = $clog2(BUS_TIMEOUT_CYCLES + 1);

  bridge_state_e state, state_nxt;
  logic [BTW-1:0] bus_timer;
  logic [7:0]     status_q, resp_q;
  logic           frame_done, frame_bad, frame_drop;
  logic           f_rw;
  logic [15:0]    f_addr;
  logic [7:0]     f_wdata;
  logic           bus_run, bus_expire, xfer_done;
  logic           addr_load, resp_load;
  logic [7:0]     resp_status, resp_byte;

  bus_bridge_frame_rx #(
    .BYTE_TIMEOUT_CYCLES(BYTE_TIMEOUT_CYCLES)
  ) u_frame_rx (
    .clk       (clk),
    .rst_n     (rst_n),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_en     (state == ST_IDLE || state == ST_RX_FRAME),
    .rx_first  (state == ST_IDLE),
    .frame_done(frame_done),
    .frame_bad (frame_bad),
    .frame_drop(frame_drop),
    .rw        (f_rw),
    .addr      (f_addr),
    .wdata     (f_wdata)
  );

  // A split target freezes the bus timer so long splits never time out.
  assign bus_run    = (state == ST_REQ || state == ST_WAIT) && !m_split_ack;
  assign bus_expire = bus_run && (bus_timer == BTW'(BUS_TIMEOUT_CYCLES - 1));
  assign xfer_done  = (state == ST_WAIT) && (f_rw ? m_ack : m_data_in_valid);

  // NOTE: every signal written here gets a default first, so no path leaves one
  // unassigned and no latch is inferred.
  always_comb begin
    state_nxt   = state;
    addr_load   = 1'b0;
    resp_load   = 1'b0;
    resp_status = STATUS_OK;
    resp_byte   = 8'h00;
    case (state)
      ST_IDLE:     if (rx_valid) state_nxt = ST_RX_FRAME;
      ST_RX_FRAME: begin
        if (frame_drop) begin
          state_nxt = ST_IDLE;
        end else if (frame_done && frame_bad) begin
          state_nxt   = ST_RESP0;
          resp_load   = 1'b1;
          resp_status = STATUS_BADSUM;
        end else if (frame_done) begin
          state_nxt = ST_REQ;
        end
      end
      ST_REQ: begin
        if (m_grant) begin
          state_nxt = ST_ADDR;
          addr_load = 1'b1;
        end else if (bus_expire) begin
          state_nxt   = ST_RESP0;
          resp_load   = 1'b1;
          resp_status = STATUS_TIMEOUT;
        end
      end
      ST_ADDR:     state_nxt = ST_WAIT;
      ST_WAIT: begin
        if (xfer_done) begin
          state_nxt = ST_RESP0;
          resp_load = 1'b1;
          resp_byte = f_rw ? f_wdata : m_data_in;
        end else if (bus_expire) begin
          state_nxt   = ST_RESP0;
          resp_load   = 1'b1;
          resp_status = STATUS_TIMEOUT;
        end
      end
      ST_RESP0:    if (tx_ready) state_nxt = ST_RESP1;
      ST_RESP1:    if (tx_ready) state_nxt = ST_IDLE;
      default:     state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= ST_IDLE;
      bus_timer     <= '0;
      m_address_out <= '0;
      m_data_out    <= '0;
      m_rw          <= 1'b0;
      status_q      <= '0;
      resp_q        <= '0;
    end else begin
      state <= state_nxt;
      if (state_nxt == ST_REQ && state != ST_REQ) begin
        bus_timer <= '0;
      end else if (bus_run) begin
        bus_timer <= bus_timer + BTW'(1);
      end
      if (addr_load) begin
        m_address_out <= f_addr;
        m_rw          <= f_rw;
        if (f_rw) m_data_out <= f_wdata;
      end
      if (resp_load) begin
        status_q <= resp_status;
        resp_q   <= resp_byte;
      end
    end
  end

  assign busy                = (state != ST_IDLE);
  assign m_req               = (state == ST_REQ) || (state == ST_ADDR) || (state == ST_WAIT);
  assign m_address_out_valid = (state == ST_ADDR);
  assign m_data_out_valid    = (state == ST_ADDR) && f_rw;
  assign m_ready             = (state == ST_WAIT) && !f_rw;
  assign tx_valid            = (state == ST_RESP0) || (state == ST_RESP1);
  assign tx_data             = (state == ST_RESP1) ? resp_q : status_q;

endmodule

// File: tb/tb_bus_bridge_m_frame_ctrl.sv
// Self-checking bench for bus_bridge_m_frame_ctrl: directed table, hand-written corner
// sequences and random transactions against a frame-level response model.
module tb_bus_bridge_m_frame_ctrl;

  localparam int BYTE_TO = 50000;
  localparam int BUS_TO  = 4096;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  rx_data = '0;
  logic        rx_valid = 1'b0;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready = 1'b0;
  logic        m_req;
  logic        m_grant = 1'b0;
  logic [15:0] m_address_out;
  logic        m_address_out_valid;
  logic [7:0]  m_data_out;
  logic        m_data_out_valid;
  logic        m_rw;
  logic        m_ready;
  logic [7:0]  m_data_in = '0;
  logic        m_data_in_valid = 1'b0;
  logic        m_ack = 1'b0;
  logic        m_split_ack = 1'b0;
  logic        busy;

  int vectors = 0;
  int miscompares = 0;

  bus_bridge_m_frame_ctrl #(
    .BYTE_TIMEOUT_CYCLES(BYTE_TO),
    .BUS_TIMEOUT_CYCLES (BUS_TO),
    .STATUS_OK          (8'h00),
    .STATUS_TIMEOUT     (8'hEE)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .rx_data(rx_data), .rx_valid(rx_valid),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .m_req(m_req), .m_grant(m_grant),
    .m_address_out(m_address_out), .m_address_out_valid(m_address_out_valid),
    .m_data_out(m_data_out), .m_data_out_valid(m_data_out_valid),
    .m_rw(m_rw), .m_ready(m_ready),
    .m_data_in(m_data_in), .m_data_in_valid(m_data_in_valid),
    .m_ack(m_ack), .m_split_ack(m_split_ack),
    .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] cmd, ah, al, wd, rdata;
    int         grant_dly, resp_dly, split;
    bit         no_resp, bad_sum, stray;
    logic [7:0] exp_status, exp_data;
  } txn_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic txn_t mk(input logic [7:0] cmd, ah, al, wd, rdata,
                              input int g, r, s, input bit no_resp, bad,
                              input logic [7:0] es, ed);
    txn_t t;
    t.cmd = cmd; t.ah = ah; t.al = al; t.wd = wd; t.rdata = rdata;
    t.grant_dly = g; t.resp_dly = r; t.split = s;
    t.no_resp = no_resp; t.bad_sum = bad; t.stray = 1'b0;
    t.exp_status = es; t.exp_data = ed;
    return t;
  endfunction

  // Frame-level model: what the response frame must contain for a transaction.
  function automatic void ref_resp(input txn_t t, output logic [7:0] st, output logic [7:0] d);
    if (t.bad_sum)      begin st = 8'hCE; d = 8'h00; end
    else if (t.no_resp) begin st = 8'hEE; d = 8'h00; end
    else                begin st = 8'h00; d = t.cmd[0] ? t.wd : t.rdata; end
  endfunction

  task automatic send_frame(input txn_t t);
    logic [7:0] fb [5];
    int n = 4;
    fb[0] = t.cmd; fb[1] = t.ah; fb[2] = t.al; fb[3] = t.wd; fb[4] = 8'h00;
`ifdef BRIDGE_M_CHECKSUM_EN
    fb[4] = fb[0] ^ fb[1] ^ fb[2] ^ fb[3] ^ (t.bad_sum ? 8'hFF : 8'h00);
    n = 5;
`endif
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      rx_data  = fb[i];
      rx_valid = 1'b1;
    end
  endtask

  // Sends one frame, plays the Bus-B target, collects the response and checks it.
  task automatic run_txn(input txn_t t);
    int cyc = 0, req_rise = -1, addr_cyc = -1, done_cyc = -1;
    int n_addr = 0, req_hi = 0, req_gap = 0, k;
    logic [15:0] cap_addr = '0;
    logic [7:0]  cap_d = '0, prev_tx = '0;
    logic        cap_rw = 1'b0, cap_dv = 1'b0, stalled = 1'b0;
    logic        req_after = 1'b1, ready_after = 1'b1;
    logic [7:0]  rsp[$];
    send_frame(t);
    while (rsp.size() < 2 && cyc < 20000) begin
      @(negedge clk);
      if (m_req) begin
        req_hi++;
        if (req_rise < 0) req_rise = cyc;
      end else if (req_rise >= 0 && done_cyc < 0 && !tx_valid) begin
        req_gap++;
      end
      if (m_address_out_valid) begin
        n_addr++; addr_cyc = cyc;
        cap_addr = m_address_out; cap_rw = m_rw; cap_dv = m_data_out_valid; cap_d = m_data_out;
      end
      if (done_cyc >= 0 && cyc == done_cyc + 1) begin
        req_after = m_req; ready_after = m_ready;
      end
      if (stalled) begin
        check("tx_hold_valid", tx_valid, 1'b1);
        check("tx_hold_data", tx_data, prev_tx);
      end
      rx_valid        = t.stray && (cyc == 1);
      rx_data         = 8'hA5;
      m_grant         = m_req && (cyc >= t.grant_dly) && (addr_cyc < 0);
      m_split_ack     = 1'b0;
      m_ack           = 1'b0;
      m_data_in_valid = 1'b0;
      m_data_in       = 8'($urandom);
      if (addr_cyc >= 0 && !t.no_resp) begin
        k = cyc - addr_cyc;
        if (k >= 1 && k <= t.split) begin
          m_split_ack = 1'b1;
        end else if (k == t.split + 1 + t.resp_dly) begin
          done_cyc = cyc;
          if (t.cmd[0]) m_ack = 1'b1;
          else begin
            m_data_in_valid = 1'b1;
            m_data_in       = t.rdata;
            check("m_ready_wait", m_ready, 1'b1);
          end
        end
      end
      tx_ready = 1'($urandom_range(0, 1));
      stalled  = tx_valid && !tx_ready;
      prev_tx  = tx_data;
      if (tx_valid && tx_ready) rsp.push_back(tx_data);
      cyc++;
    end
    rx_valid = 1'b0; m_grant = 1'b0; m_split_ack = 1'b0; m_ack = 1'b0; m_data_in_valid = 1'b0;
    if (rsp.size() < 2) begin
      check("resp_bytes_budget", rsp.size(), 2);
      return;
    end
    @(negedge clk);
    tx_ready = 1'b0;
    check("busy_after_resp", busy, 1'b0);
    check("resp_status", rsp[0], t.exp_status);
    check("resp_data", rsp[1], t.exp_data);
    if (!t.bad_sum) begin
      check("req_latency", req_rise, 0);
      check("addr_count", n_addr, 1);
      check("addr_latency", addr_cyc, t.grant_dly + 1);
      check("addr_value", cap_addr, {t.ah, t.al});
      check("addr_rw", cap_rw, t.cmd[0]);
      check("wdata_valid", cap_dv, t.cmd[0]);
      if (t.cmd[0]) check("wdata_value", cap_d, t.wd);
      check("req_continuous", req_gap, 0);
      if (t.no_resp) begin
        check("timeout_window", (req_hi >= BUS_TO - 2) && (req_hi <= BUS_TO + 4), 1'b1);
      end else begin
        check("req_drop_after_done", req_after, 1'b0);
        check("ready_drop_after_done", ready_after, 1'b0);
        if (t.split > 0) check("req_through_split", req_hi > t.split, 1'b1);
      end
    end else begin
      check("badsum_no_addr", n_addr, 0);
      check("badsum_no_req", req_hi, 0);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    txn_t vec[$];
    txn_t t;
    logic [7:0] st, d;
    bit seen;

    #3;
    check("reset_outputs",
          {tx_valid, m_req, m_address_out, m_address_out_valid, m_data_out,
           m_data_out_valid, m_rw, m_ready, busy}, '0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;

    vec.push_back(mk(8'h01, 8'h40, 8'h12, 8'hA7, 8'h00, 0, 0, 0,    0, 0, 8'h00, 8'hA7));
    vec.push_back(mk(8'h00, 8'h00, 8'h34, 8'h5A, 8'h3C, 0, 4, 0,    0, 0, 8'h00, 8'h3C));
    vec.push_back(mk(8'h00, 8'h12, 8'h34, 8'h00, 8'h5E, 0, 2, 6000, 0, 0, 8'h00, 8'h5E));
    vec.push_back(mk(8'h01, 8'hAB, 8'hCD, 8'h99, 8'h00, 0, 0, 0,    1, 0, 8'hEE, 8'h00));
    vec.push_back(mk(8'hFF, 8'hFF, 8'hFF, 8'h00, 8'h11, 3, 1, 0,    0, 0, 8'h00, 8'h00));
    vec.push_back(mk(8'hFE, 8'h00, 8'h00, 8'h77, 8'hFF, 2, 0, 0,    0, 0, 8'h00, 8'hFF));
    foreach (vec[i]) run_txn(vec[i]);

    // Partial frame followed by a long idle gap must be discarded silently.
    @(negedge clk); rx_data = 8'h01; rx_valid = 1'b1;
    @(negedge clk); rx_data = 8'h55;
    @(negedge clk); rx_valid = 1'b0;
    check("partial_busy", busy, 1'b1);
    repeat (BYTE_TO + 10) @(negedge clk);
    check("partial_dropped", busy, 1'b0);
    check("partial_no_tx", tx_valid, 1'b0);
    run_txn(mk(8'h01, 8'h66, 8'h77, 8'h88, 8'h00, 0, 0, 0, 0, 0, 8'h00, 8'h88));

    for (int i = 0; i < 24; i++) begin
      t = mk(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom),
             $urandom_range(0, 5), $urandom_range(0, 5), $urandom_range(0, 20), 0, 0, 0, 0);
`ifdef BRIDGE_M_CHECKSUM_EN
      t.bad_sum = ($urandom_range(0, 7) == 0);
`endif
      t.stray = 1'($urandom_range(0, 1));
      ref_resp(t, st, d);
      t.exp_status = st;
      t.exp_data   = d;
      run_txn(t);
    end

    // Asynchronous reset while waiting on the bus.
    send_frame(mk(8'h00, 8'h11, 8'h22, 8'h33, 8'h00, 0, 0, 0, 0, 0, 0, 0));
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      rx_valid = 1'b0;
      if (m_address_out_valid) begin
        seen = 1'b1;
        break;
      end
      m_grant = m_req;
    end
    m_grant = 1'b0;
    check("rst_addr_seen", seen, 1'b1);
    @(negedge clk);
    check("rst_in_wait", m_ready, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check("rst_async_outputs",
          {tx_valid, m_req, m_address_out, m_address_out_valid, m_data_out,
           m_data_out_valid, m_rw, m_ready}, '0);
    check("rst_async_busy", busy, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    run_txn(mk(8'h01, 8'h80, 8'h04, 8'h05, 8'h00, 0, 0, 0, 0, 0, 8'h00, 8'h05));
`ifdef BRIDGE_M_CHECKSUM_EN
    run_txn(mk(8'h01, 8'h80, 8'h04, 8'h05, 8'h00, 0, 0, 0, 0, 1, 8'hCE, 8'h00));
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
